// File: rtl/ram_arbiter.sv
// Round-robin two-port arbiter that sequences one access at a time into a
// single-port synchronous ram with one-cycle read latency.
module ram_arbiter #(
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p0_req_valid,
  output logic          p0_req_ready,
  input  logic          p0_req_write,
  input  logic [AW-1:0] p0_req_addr,
  input  logic [DW-1:0] p0_req_wdata,
  output logic          p0_rsp_valid,
  output logic [DW-1:0] p0_rsp_rdata,
  input  logic          p1_req_valid,
  output logic          p1_req_ready,
  input  logic          p1_req_write,
  input  logic [AW-1:0] p1_req_addr,
  input  logic [DW-1:0] p1_req_wdata,
  output logic          p1_rsp_valid,
  output logic [DW-1:0] p1_rsp_rdata,
  output logic          ram_write,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data,
  input  logic [DW-1:0] ram_out
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t        state_reg;
  logic          last_reg;
  logic          owner_reg;
  logic          write_reg;
  logic          ram_write_reg;
  logic [AW-1:0] ram_addr_reg;
  logic [DW-1:0] ram_data_reg;
  logic [1:0]    rsp_valid_reg;

  logic [1:0]    valid_vec;
  logic [1:0]    ready_vec;
  logic [1:0]    rsp_valid_vec;
  logic [DW-1:0] rdata_arr [2];
  logic          accepting;
  logic          grant;
  logic          winner;
  logic          sel_write;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [DW-1:0] resp_data;

  assign valid_vec = {p1_req_valid, p0_req_valid};
  assign accepting = rst_n && (state_reg == IDLE || state_reg == RESP);
  assign grant     = accepting && (|valid_vec);
  // On a tie the port that did not win last time gets the grant.
  assign winner    = (&valid_vec) ? ~last_reg : valid_vec[1];

  assign sel_write = winner ? p1_req_write : p0_req_write;
  assign sel_addr  = winner ? p1_req_addr  : p0_req_addr;
  assign sel_wdata = winner ? p1_req_wdata : p0_req_wdata;

  // ram_out floats after a write edge, so write acks return zero instead.
  assign resp_data = write_reg ? '0 : ram_out;

  // Gating with rst_n kills a write whose ram edge coincides with reset.
  assign ram_write = ram_write_reg & rst_n;
  assign ram_addr  = ram_addr_reg;
  assign ram_data  = ram_data_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      last_reg      <= 1'b1;
      owner_reg     <= 1'b0;
      write_reg     <= 1'b0;
      ram_write_reg <= 1'b0;
      ram_addr_reg  <= '0;
      ram_data_reg  <= '0;
      rsp_valid_reg <= 2'b00;
    end else begin
      ram_write_reg <= 1'b0;
      rsp_valid_reg <= 2'b00;
      case (state_reg)
        ISSUE: begin
          rsp_valid_reg[owner_reg] <= 1'b1;
          state_reg                <= RESP;
        end
        default: begin
          if (grant) begin
            ram_write_reg <= sel_write;
            ram_addr_reg  <= sel_addr;
            ram_data_reg  <= sel_wdata;
            write_reg     <= sel_write;
            owner_reg     <= winner;
            last_reg      <= winner;
            state_reg     <= ISSUE;
          end else begin
            state_reg     <= IDLE;
          end
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [DW-1:0] hold_reg;

      assign ready_vec[gi]     = grant && (winner == 1'(gi));
      assign rsp_valid_vec[gi] = rsp_valid_reg[gi] & rst_n;
      assign rdata_arr[gi]     = rsp_valid_reg[gi] ? resp_data : hold_reg;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          hold_reg <= '0;
        end else if (rsp_valid_reg[gi]) begin
          hold_reg <= resp_data;
        end
      end
    end
  endgenerate

  assign p0_req_ready = ready_vec[0];
  assign p1_req_ready = ready_vec[1];
  assign p0_rsp_valid = rsp_valid_vec[0];
  assign p1_rsp_valid = rsp_valid_vec[1];
  assign p0_rsp_rdata = rdata_arr[0];
  assign p1_rsp_rdata = rdata_arr[1];
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural ram, golden memory and a per-port
// response scoreboard filled on accept and drained when responses appear.
module tb_ram_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          p0_req_valid, p0_req_ready, p0_req_write, p0_rsp_valid;
  logic [AW-1:0] p0_req_addr;
  logic [DW-1:0] p0_req_wdata, p0_rsp_rdata;
  logic          p1_req_valid, p1_req_ready, p1_req_write, p1_rsp_valid;
  logic [AW-1:0] p1_req_addr;
  logic [DW-1:0] p1_req_wdata, p1_rsp_rdata;
  logic          ram_write;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic [DW-1:0] ram_out;

  ram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_write(p0_req_write),
    .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
    .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_write(p1_req_write),
    .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
    .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata),
    .ram_write(ram_write), .ram_addr(ram_addr), .ram_data(ram_data), .ram_out(ram_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port ram; the pre_* port loads contents while the DUT is idle.
  logic [DW-1:0] ram_mem [4096];
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;
  always @(posedge clk) begin
    if (pre_en) begin
      ram_mem[pre_addr] <= pre_data;
    end else if (ram_write) begin
      ram_mem[ram_addr] <= ram_data;
      ram_out <= 'z;
    end else begin
      ram_out <= ram_mem[ram_addr];
    end
  end

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            cyc;
  } exp_t;

  exp_t          sbq [2][$];
  logic [DW-1:0] ref_mem [4096];
  logic [DW-1:0] hold_exp [2];
  logic [DW-1:0] last_rsp [2];
  int            rsp_count [2];
  int            last_rsp_cyc [2];
  int            grant_log [$];
  int            acc_cyc [$];
  int            vectors = 0;
  int            miscompares = 0;

  logic [1:0]    mon_v;
  logic [DW-1:0] mon_d [2];
  exp_t          mon_e;
  logic [DW-1:0] mon_exp;
  assign mon_v    = {p1_rsp_valid, p0_rsp_valid};
  assign mon_d[0] = p0_rsp_rdata;
  assign mon_d[1] = p1_rsp_rdata;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int p = 0; p < 2; p++) begin
        sbq[p].delete();
        hold_exp[p] = '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        vectors++;
        if (mon_v[p]) begin
          if (sbq[p].size() == 0) begin
            miscompares++;
            $display("FAIL rsp_unexpected p%0d: got rsp_valid=1 rdata=%h, required no response", p, mon_d[p]);
          end else begin
            mon_e   = sbq[p].pop_front();
            mon_exp = mon_e.write ? '0 : ref_mem[mon_e.addr];
            if (mon_e.write) ref_mem[mon_e.addr] = mon_e.wdata;
            if (mon_d[p] !== mon_exp || cyc != mon_e.cyc) begin
              miscompares++;
              $display("FAIL rsp_p%0d addr=%h: got rdata=%h at cycle %0d, required rdata=%h at cycle %0d",
                       p, mon_e.addr, mon_d[p], cyc, mon_exp, mon_e.cyc);
            end
            hold_exp[p] = mon_exp;
          end
          last_rsp[p]     = mon_d[p];
          last_rsp_cyc[p] = cyc;
          rsp_count[p]++;
        end else begin
          if (mon_d[p] !== hold_exp[p]) begin
            miscompares++;
            $display("FAIL rdata_hold p%0d: got %h, required %h", p, mon_d[p], hold_exp[p]);
          end
          if (sbq[p].size() != 0 && sbq[p][0].cyc < cyc) begin
            miscompares++;
            $display("FAIL rsp_missing p%0d: got no rsp_valid by cycle %0d, required at cycle %0d", p, cyc, sbq[p][0].cyc);
            void'(sbq[p].pop_front());
          end
        end
      end
      vectors++;
      if (p0_req_ready && p1_req_ready) begin
        miscompares++;
        $display("FAIL ready_exclusive: got both ready=1, required at most one");
      end
      if (p0_req_valid && p0_req_ready) begin
        sbq[0].push_back('{p0_req_write, p0_req_addr, p0_req_wdata, cyc + 2});
        grant_log.push_back(0);
        acc_cyc.push_back(cyc);
      end
      if (p1_req_valid && p1_req_ready) begin
        sbq[1].push_back('{p1_req_write, p1_req_addr, p1_req_wdata, cyc + 2});
        grant_log.push_back(1);
        acc_cyc.push_back(cyc);
      end
    end
  end

  task automatic drive(input int p, input logic v, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin
      p0_req_valid = v; p0_req_write = w; p0_req_addr = a; p0_req_wdata = d;
    end else begin
      p1_req_valid = v; p1_req_write = w; p1_req_addr = a; p1_req_wdata = d;
    end
  endtask

  // Presents one request and returns just after its accepting edge; keep leaves valid high.
  task automatic req(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit keep);
    bit ok = 1'b0;
    @(posedge clk); #1;
    drive(p, 1'b1, w, a, d);
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = (p == 0) ? p0_req_ready : p1_req_ready;
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL accept_timeout p%0d addr=%h: got no ready in 20 cycles, required ready", p, a);
    end
    @(posedge clk); #1;
    drive(p, keep, w, a, d);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk); #1;
      done = (sbq[0].size() == 0) && (sbq[1].size() == 0);
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL drain_timeout: got %0d/%0d pending rsps, required 0/0", sbq[0].size(), sbq[1].size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(posedge clk); #1;
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    ref_mem[a] = d;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 1'b1, 1'b1, 12'habc, 32'hdeadbeef);
    drive(1, 1'b1, 1'b0, 12'h123, 32'h12345678);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (p0_req_ready !== 1'b0 || p1_req_ready !== 1'b0 || ram_write !== 1'b0 || ram_addr !== '0 ||
          ram_data !== '0 || p0_rsp_valid !== 1'b0 || p1_rsp_valid !== 1'b0 ||
          p0_rsp_rdata !== '0 || p1_rsp_rdata !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs: got rdy=%b%b wr=%b addr=%h data=%h rsp=%b%b rdata=%h/%h, required all 0",
                 p0_req_ready, p1_req_ready, ram_write, ram_addr, ram_data, p0_rsp_valid, p1_rsp_valid,
                 p0_rsp_rdata, p1_rsp_rdata);
      end
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    req(1, 1'b1, 12'h005, 32'h0000abba, 1'b0);
    wait_idle();
    vectors++;
    if (last_rsp[1] !== 32'h0) begin
      miscompares++;
      $display("FAIL write_ack_rdata: got %h, required 00000000", last_rsp[1]);
    end
    req(1, 1'b0, 12'h005, '0, 1'b0);
    wait_idle();
    vectors++;
    if (last_rsp[1] !== 32'h0000abba) begin
      miscompares++;
      $display("FAIL read_back: got %h, required 0000abba", last_rsp[1]);
    end
    vectors++;
    if (last_rsp_cyc[1] - acc_cyc[$] != 2) begin
      miscompares++;
      $display("FAIL read_latency: got %0d cycles, required 2", last_rsp_cyc[1] - acc_cyc[$]);
    end
  endtask

  task automatic test_alternate();
    int c0, c1;
    preload(12'h010, 32'h0000fefe);
    preload(12'h020, 32'h00001313);
    do_reset();
    grant_log.delete();
    c0 = rsp_count[0];
    c1 = rsp_count[1];
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 12'h010, '0);
    drive(1, 1'b1, 1'b0, 12'h020, '0);
    for (int i = 0; i < 40 && grant_log.size() < 8; i++) begin
      @(posedge clk); #1;
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    wait_idle();
    vectors++;
    if (grant_log.size() != 8) begin
      miscompares++;
      $display("FAIL grant_count: got %0d grants, required 8", grant_log.size());
    end
    for (int i = 0; i < grant_log.size() && i < 8; i++) begin
      vectors++;
      if (grant_log[i] != i % 2) begin
        miscompares++;
        $display("FAIL grant_order[%0d]: got p%0d, required p%0d", i, grant_log[i], i % 2);
      end
    end
    vectors++;
    if (rsp_count[0] - c0 != 4 || rsp_count[1] - c1 != 4) begin
      miscompares++;
      $display("FAIL rsp_split: got p0=%0d p1=%0d, required 4/4", rsp_count[0] - c0, rsp_count[1] - c1);
    end
  endtask

  task automatic test_back_to_back();
    int c1;
    for (int i = 0; i < 8; i++) preload(AW'(i), 32'h5a000000 + 32'(i * 7));
    c1 = rsp_count[1];
    acc_cyc.delete();
    for (int i = 0; i < 8; i++) req(0, 1'b0, AW'(i), '0, i < 7);
    wait_idle();
    vectors++;
    if (acc_cyc.size() != 8) begin
      miscompares++;
      $display("FAIL b2b_accepts: got %0d, required 8", acc_cyc.size());
    end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      vectors++;
      if (acc_cyc[i] - acc_cyc[i-1] != 2) begin
        miscompares++;
        $display("FAIL accept_spacing[%0d]: got %0d cycles, required 2", i, acc_cyc[i] - acc_cyc[i-1]);
      end
    end
    vectors++;
    if (rsp_count[1] != c1) begin
      miscompares++;
      $display("FAIL p1_quiet: got %0d p1 rsps, required 0", rsp_count[1] - c1);
    end
  endtask

  task automatic test_reset_drop();
    int  c0;
    bit  ok = 1'b0;
    preload(12'h001, 32'h0000badd);
    c0 = rsp_count[0];
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b1, 12'h001, 32'h00006969);
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = p0_req_ready;
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL drop_accept: got no ready, required ready");
    end
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, '0, '0);
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if (ram_write !== 1'b0) begin
      miscompares++;
      $display("FAIL write_suppress: got ram_write=%b during reset, required 0", ram_write);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if (rsp_count[0] != c0) begin
      miscompares++;
      $display("FAIL dropped_rsp: got %0d rsps, required 0", rsp_count[0] - c0);
    end
    req(0, 1'b0, 12'h001, '0, 1'b0);
    wait_idle();
    vectors++;
    if (last_rsp[0] !== 32'h0000badd) begin
      miscompares++;
      $display("FAIL old_value: got %h, required 0000badd", last_rsp[0]);
    end
  endtask

  task automatic test_same_addr();
    do_reset();
    grant_log.delete();
    fork
      req(0, 1'b1, 12'h0ff, 32'h00001111, 1'b0);
      req(1, 1'b1, 12'h0ff, 32'h00002222, 1'b0);
    join
    wait_idle();
    vectors++;
    if (grant_log.size() != 2) begin
      miscompares++;
      $display("FAIL same_addr_grants: got %0d grants, required 2", grant_log.size());
    end else if (grant_log[0] != 0 || grant_log[1] != 1) begin
      miscompares++;
      $display("FAIL same_addr_order: got p%0d,p%0d, required p0,p1", grant_log[0], grant_log[1]);
    end
    req(0, 1'b0, 12'h0ff, '0, 1'b0);
    wait_idle();
    vectors++;
    if (last_rsp[0] !== 32'h00002222) begin
      miscompares++;
      $display("FAIL same_addr_final: got %h, required 00002222", last_rsp[0]);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_alternate();
    test_back_to_back();
    test_reset_drop();
    test_same_addr();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by time limit, required $finish");
    $fatal(1, "watchdog expired");
  end
endmodule
